// File: rtl/fifo_fwft.sv
// First-word-fall-through FIFO built on an internal register array, with count-based status flags.
// Optional sticky overflow/underflow flags are enabled by defining FIFO_STICKY_ERR_EN.
module fifo_fwft #(
  parameter int WIDTH     = 4,
  parameter int ADDR_BITS = 5,
  parameter int AF_LEVEL  = (2 ** ADDR_BITS) - 2,
  parameter int AE_LEVEL  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [WIDTH-1:0]     pushedValue,
  input  logic                 pop,
  output logic [WIDTH-1:0]     poppedValue,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [ADDR_BITS:0]   count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS:0]   DEPTH_C  = (ADDR_BITS + 1)'(DEPTH);
  localparam logic [ADDR_BITS:0]   AF_C     = (ADDR_BITS + 1)'(AF_LEVEL);
  localparam logic [ADDR_BITS:0]   AE_C     = (ADDR_BITS + 1)'(AE_LEVEL);
  localparam logic [ADDR_BITS:0]   CNT_ZERO = {(ADDR_BITS + 1){1'b0}};
  localparam logic [ADDR_BITS:0]   CNT_ONE  = (ADDR_BITS + 1)'(1);
  localparam logic [ADDR_BITS-1:0] PTR_ZERO = {ADDR_BITS{1'b0}};
  localparam logic [ADDR_BITS-1:0] PTR_ONE  = ADDR_BITS'(1);

  logic [WIDTH-1:0]     mem_r [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr_r;
  logic [ADDR_BITS-1:0] rd_ptr_r;
  logic [ADDR_BITS:0]   count_r;
  logic [ADDR_BITS:0]   count_next_s;
  logic                 empty_r;
  logic                 full_r;
  logic                 almost_full_r;
  logic                 almost_empty_r;
  logic                 push_ok_s;
  logic                 pop_ok_s;

  // Acceptance rules and next occupancy; a full FIFO still takes a push when a pop frees a slot.
  always_comb begin
    pop_ok_s     = pop && !empty_r;
    push_ok_s    = push && (!full_r || pop);
    count_next_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // Pointers, count and flags; flags are decoded from the next count so they track count exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r       <= PTR_ZERO;
      rd_ptr_r       <= PTR_ZERO;
      count_r        <= CNT_ZERO;
      empty_r        <= 1'b1;
      full_r         <= 1'b0;
      almost_full_r  <= 1'b0;
      almost_empty_r <= 1'b1;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r        <= count_next_s;
      empty_r        <= (count_next_s == CNT_ZERO);
      full_r         <= (count_next_s == DEPTH_C);
      almost_full_r  <= (count_next_s >= AF_C);
      almost_empty_r <= (count_next_s <= AE_C);
    end
  end

  // Storage array; contents are deliberately left untouched by reset.
  always_ff @(posedge clk) begin
    if (push_ok_s && !reset) begin
      mem_r[wr_ptr_r] <= pushedValue;
    end
  end

`ifdef FIFO_STICKY_ERR_EN
  logic overflow_r;
  logic underflow_r;

  // Sticky error capture: rejected push and ignored pop latch until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (push && full_r && !pop) begin
        overflow_r <= 1'b1;
      end
      if (pop && empty_r) begin
        underflow_r <= 1'b1;
      end
    end
  end

  assign overflow  = overflow_r;
  assign underflow = underflow_r;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign poppedValue  = empty_r ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];
  assign empty        = empty_r;
  assign full         = full_r;
  assign almost_full  = almost_full_r;
  assign almost_empty = almost_empty_r;
  assign count        = count_r;

endmodule

// File: doc/fifo_fwft.md
FIFO_FWFT -- requirements
Module: fifo_fwft

Interface
REQ-001 SHALL have parameter WIDTH, default 4, data word width in bits (>=1).
REQ-002 SHALL have parameter ADDR_BITS, default 5, address width; DEPTH = 2**ADDR_BITS entries (ADDR_BITS>=1).
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2, count at or above which almost_full asserts.
REQ-004 SHALL have parameter AE_LEVEL, default 2, count at or below which almost_empty asserts.
REQ-005 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous active-high reset.
REQ-007 SHALL have port push  input  1  write request for pushedValue.
REQ-008 SHALL have port pushedValue  input  WIDTH  data to write.
REQ-009 SHALL have port pop  input  1  consume head word.
REQ-010 SHALL have port poppedValue  output  WIDTH  current head word (first-word-fall-through).
REQ-011 SHALL have ports empty, full, almost_full, almost_empty  output  1 each  status flags.
REQ-012 SHALL have port count  output  ADDR_BITS+1  number of stored words, 0..DEPTH.
REQ-013 SHALL have ports overflow, underflow  output  1 each  error flags (see Configuration).

Function
REQ-014 SHALL store data in an internal DEPTH x WIDTH register array; no external RAM instance.
REQ-015 SHALL drive poppedValue = array[read pointer] combinationally when !empty, and all-zero when empty.
REQ-016 SHALL make a word pushed into an empty FIFO visible on poppedValue and clear empty the cycle after the push edge (1-cycle write-to-read latency).
REQ-017 SHALL accept push when !full, or when full and pop is also asserted the same cycle.
REQ-018 SHALL accept pop only when !empty; pop on empty is ignored, push in the same cycle still accepted.
REQ-019 SHALL on accepted push write array[write pointer], advance write pointer modulo DEPTH.
REQ-020 SHALL on accepted pop advance read pointer modulo DEPTH.
REQ-021 SHALL update count: +1 push only, -1 pop only, unchanged when both accepted or neither.
REQ-022 SHALL derive empty = (count==0), full = (count==DEPTH), almost_full = (count>=AF_LEVEL), almost_empty = (count<=AE_LEVEL), all from registered count.
REQ-023 SHALL ignore push when full without pop; stored data and pointers unchanged.
REQ-024 SHALL wrap both pointers from DEPTH-1 to 0 without data loss or flag glitch.

Reset
REQ-025 SHALL on reset clear both pointers and count to 0; empty=1, almost_empty=1, full=0, almost_full=0, poppedValue=0, overflow=0, underflow=0.
REQ-026 SHALL give reset priority over push/pop in the same cycle; array contents need not be cleared.
REQ-027 SHALL discard all stored words on reset asserted mid-operation; first push after reset appears as head.

Configuration
REQ-028 SHALL with macro FIFO_STICKY_ERR_EN defined: set overflow on rejected push (REQ-023), set underflow on ignored pop (REQ-018); both hold until reset.
REQ-029 SHALL with FIFO_STICKY_ERR_EN undefined: drive overflow and underflow constant 0 and omit their registers; all other behaviour identical.

Verification (WIDTH=4, ADDR_BITS=3, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2)
REQ-030 SHALL cover: reset, push 0xA one cycle -> next cycle empty=0, poppedValue=0xA, count=1, almost_empty=1.
REQ-031 SHALL cover: push 0x1..0x8 -> full=1, count=8, almost_full=1 from count 6; 9th push 0xF -> ignored, overflow=1 (macro on) / 0 (macro off); pop eight times -> outputs 0x1..0x8 in order, then empty=1.
REQ-032 SHALL cover: full FIFO, push 0x9 with pop same cycle -> count stays 8, head advances, 0x9 emerges after the remaining seven words.
REQ-033 SHALL cover: 20 push/pop alternations across pointer wrap -> data order preserved, count never exceeds 1.
REQ-034 SHALL cover: empty FIFO, pop alone -> count 0, underflow=1 (macro on); pop+push 0x3 on empty -> count=1, poppedValue=0x3.
REQ-035 SHALL cover: count=5, assert reset with push -> next cycle count=0, empty=1, poppedValue=0, error flags 0.
